fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NREQ requesters, the arbiter and one FIFO write port.
// master = requesters/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      fifo_wdata;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic [GID_W-1:0]      grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wdata, fifo_wr_en, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wdata, fifo_wr_en, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: muxes one of NREQ requesters onto a FIFO write port,
// holding each grant for up to BURST accepted beats. Pure combinational data path.
module fifo_wr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [OWN_W-1:0] LAST_REQ  = OWN_W'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [OWN_W-1:0] owner, owner_nxt;
  logic [OWN_W-1:0] last_owner, last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic active;
  logic owner_valid;
  logic accept;
  logic rel_grant;
  logic any_valid;

  // First valid requester after base, wrapping; base itself is considered last.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [OWN_W-1:0] base);
    logic [OWN_W-1:0] sel;
    int               best_d;
    int               d;
    sel    = base;
    best_d = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2 * NREQ - int'(base) - 1) % NREQ;
      if (v[i] && (d < best_d)) begin
        best_d = d;
        sel    = OWN_W'(i);
      end
    end
    return sel;
  endfunction

  // Reset gates every output in the same cycle so a mid-burst reset never writes.
  always_comb begin
    active      = (state == GRANT) && !rst;
    owner_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OWN_W'(i)) owner_valid = bus.req_valid[i];
    end
    any_valid = |bus.req_valid;
    accept    = active && owner_valid && !bus.fifo_full;
    rel_grant = active && (!owner_valid || (accept && (beat_cnt == LAST_BEAT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_REQ;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt    = GRANT;
          owner_nxt    = rr_pick(bus.req_valid, last_owner);
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (rel_grant) begin
          last_owner_nxt = owner;
          beat_cnt_nxt   = '0;
          // Back-to-back handover: the releasing owner is scanned last.
          if (any_valid) owner_nxt = rr_pick(bus.req_valid, owner);
          else           state_nxt = IDLE;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wdata = '0;
    bus.fifo_wr_en = accept;
    bus.busy       = active;
    bus.grant_id   = '0;
    if (active) begin
      bus.grant_id = owner;
      for (int i = 0; i < NREQ; i++) begin
        if (owner == OWN_W'(i)) begin
          bus.req_ready[i] = !bus.fifo_full;
          bus.fifo_wdata   = bus.req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-table bench for fifo_wr_arbiter: BURST=4 and BURST=1 instances share stimulus;
// expected writes go through a queue and are matched against the FIFO port.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(32), .NREQ(4)) bus4 ();
  fifo_wr_arbiter_if #(.WIDTH(32), .NREQ(4)) bus1 ();

  fifo_wr_arbiter #(.WIDTH(32), .NREQ(4), .BURST(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  fifo_wr_arbiter #(.WIDTH(32), .NREQ(4), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct {
    bit       rst;
    bit [3:0] v;
    bit       full;
    bit       b1;
    bit       busy;
    bit [1:0] gid;
    bit       wr;
    bit [3:0] rdy;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          seq[4];
  int          checks = 0;
  int          errors = 0;

  function automatic void add(bit r, bit [3:0] v, bit full, bit b1,
                              bit busy, bit [1:0] gid, bit wr, bit [3:0] rdy);
    vec_t e;
    e.rst = r; e.v = v; e.full = full; e.b1 = b1;
    e.busy = busy; e.gid = gid; e.wr = wr; e.rdy = rdy;
    tbl.push_back(e);
  endfunction

  function automatic void idle(bit r, bit [3:0] v, bit b1);
    add(r, v, 1'b0, b1, 1'b0, 2'd0, 1'b0, 4'b0000);
  endfunction

  function automatic void own(bit [3:0] v, bit full, bit b1, bit [1:0] gid, bit wr);
    bit [3:0] rdy;
    rdy = full ? 4'b0000 : (4'b0001 << gid);
    add(1'b0, v, full, b1, 1'b1, gid, wr, rdy);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL row %0d %s: got %0h want %0h", row, name, got, want);
    end
  endtask

  function automatic logic [31:0] word(int i);
    return {8'(16 + i), 24'(seq[i])};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        d_busy, d_wr;
    logic [1:0]  d_gid;
    logic [3:0]  d_rdy;
    logic [31:0] d_data, exp_w;
    vec_t        r;

    bus4.req_valid = '0; bus4.req_data = '0; bus4.fifo_full = 1'b0;
    bus1.req_valid = '0; bus1.req_data = '0; bus1.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 0;

    // Reset state, including reset with requests pending.
    idle(1, 4'b0000, 0); idle(1, 4'b1111, 0); idle(1, 4'b0000, 0);
    // Single requester, 6 words: 4-beat burst, immediate re-grant, 2 beats.
    idle(0, 4'b0001, 0);
    for (int k = 0; k < 6; k++) own(4'b0001, 0, 0, 2'd0, 1);
    own(4'b0000, 0, 0, 2'd0, 0);
    idle(0, 4'b0000, 0);
    // All requesters: 0,1,2,3,0 with 4 beats each.
    idle(1, 4'b0000, 0); idle(0, 4'b1111, 0);
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 4; k++) own(4'b1111, 0, 0, 2'(g % 4), 1);
    own(4'b0000, 0, 0, 2'd1, 0);
    idle(0, 4'b0000, 0);
    // Backpressure on owner 1 after beat 2.
    idle(1, 4'b0000, 0); idle(0, 4'b0010, 0);
    own(4'b0010, 0, 0, 2'd1, 1); own(4'b0010, 0, 0, 2'd1, 1);
    for (int k = 0; k < 3; k++) own(4'b0010, 1, 0, 2'd1, 0);
    own(4'b0010, 0, 0, 2'd1, 1); own(4'b0010, 0, 0, 2'd1, 1);
    own(4'b0000, 0, 0, 2'd1, 0);
    idle(0, 4'b0000, 0);
    // Early drop by owner 2 while requester 0 waits.
    idle(1, 4'b0000, 0); idle(0, 4'b0100, 0);
    own(4'b0101, 0, 0, 2'd2, 1);
    own(4'b0001, 0, 0, 2'd2, 0);
    own(4'b0001, 0, 0, 2'd0, 1);
    own(4'b0000, 0, 0, 2'd0, 0);
    idle(0, 4'b0000, 0);
    // Reset mid-burst of owner 3, then 0 wins over 3.
    idle(1, 4'b0000, 0); idle(0, 4'b1000, 0);
    own(4'b1000, 0, 0, 2'd3, 1); own(4'b1000, 0, 0, 2'd3, 1);
    idle(1, 4'b1000, 0);
    idle(0, 4'b1001, 0);
    own(4'b1001, 0, 0, 2'd0, 1);
    own(4'b0000, 0, 0, 2'd0, 0);
    idle(0, 4'b0000, 0);
    // BURST=1 instance: strict alternation 1,2,1,2,...
    idle(1, 4'b0000, 1); idle(0, 4'b0110, 1);
    for (int k = 0; k < 5; k++) own(4'b0110, 0, 1, (k % 2 == 0) ? 2'd1 : 2'd2, 1);
    own(4'b0000, 0, 1, 2'd2, 0);
    idle(0, 4'b0000, 1);

    @(posedge clk); #1;
    for (int n = 0; n < tbl.size(); n++) begin
      r = tbl[n];
      rst = r.rst;
      bus4.req_valid = r.v; bus4.fifo_full = r.full;
      bus1.req_valid = r.v; bus1.fifo_full = r.full;
      for (int i = 0; i < 4; i++) begin
        bus4.req_data[i*32 +: 32] = word(i);
        bus1.req_data[i*32 +: 32] = word(i);
      end
      if (r.wr) exp_q.push_back(word(int'(r.gid)));

      @(negedge clk);
      if (r.b1) begin
        d_busy = bus1.busy; d_wr = bus1.fifo_wr_en; d_gid = bus1.grant_id;
        d_rdy = bus1.req_ready; d_data = bus1.fifo_wdata;
      end else begin
        d_busy = bus4.busy; d_wr = bus4.fifo_wr_en; d_gid = bus4.grant_id;
        d_rdy = bus4.req_ready; d_data = bus4.fifo_wdata;
      end
      chk("busy", n, 32'(d_busy), 32'(r.busy));
      chk("grant_id", n, 32'(d_gid), 32'(r.gid));
      chk("fifo_wr_en", n, 32'(d_wr), 32'(r.wr));
      chk("req_ready", n, 32'(d_rdy), 32'(r.rdy));
      if (d_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", n, d_data, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          chk("fifo_wdata", n, d_data, exp_w);
        end
      end else if (!r.busy) begin
        chk("idle_wdata", n, d_data, 32'd0);
      end
      exp_q.delete();
      for (int i = 0; i < 4; i++)
        if (r.v[i] && d_rdy[i] === 1'b1) seq[i]++;

      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
